// File: rtl/alarm_sequencer_if.sv
// Alarm sequencer bus: time/alarm/key inputs and piezo control outputs.
// The master side drives time and keys; the slave side is the sequencer.
interface alarm_sequencer_if;
   logic       TICK_1HZ;
   logic [4:0] CUR_HOUR;
   logic [5:0] CUR_MIN;
   logic [5:0] CUR_SEC;
   logic [4:0] AL_HOUR;
   logic [5:0] AL_MIN;
   logic       AL_ON;
   logic       STOP_KEY;
   logic       SNOOZE_KEY;
   logic       ALARM_ENABLE;
   logic       ALARM_DOING;
   logic       SNOOZE_ON;
   logic [1:0] SNOOZE_LEFT;

   modport master (
      output TICK_1HZ,
      output CUR_HOUR,
      output CUR_MIN,
      output CUR_SEC,
      output AL_HOUR,
      output AL_MIN,
      output AL_ON,
      output STOP_KEY,
      output SNOOZE_KEY,
      input  ALARM_ENABLE,
      input  ALARM_DOING,
      input  SNOOZE_ON,
      input  SNOOZE_LEFT
   );

   modport slave (
      input  TICK_1HZ,
      input  CUR_HOUR,
      input  CUR_MIN,
      input  CUR_SEC,
      input  AL_HOUR,
      input  AL_MIN,
      input  AL_ON,
      input  STOP_KEY,
      input  SNOOZE_KEY,
      output ALARM_ENABLE,
      output ALARM_DOING,
      output SNOOZE_ON,
      output SNOOZE_LEFT
   );
endinterface

// File: rtl/alarm_sequencer.sv
// Alarm sequencer: matches clock against alarm time and sequences
// ring, snooze, stop and timeout for the piezo tone generator.
module alarm_sequencer #(
   parameter int RING_SEC   = 60,
   parameter int SNOOZE_SEC = 300,
   parameter int MAX_SNOOZE = 3
) (
   input  logic             CLK,
   input  logic             RESET,
   alarm_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARMED,
      S_RING,
      S_SNOOZE
   } state_t;

   localparam logic [8:0] RING_LAST = 9'(RING_SEC - 1);
   localparam logic [8:0] SNZ_LAST  = 9'(SNOOZE_SEC - 1);
   localparam logic [1:0] SNZ_MAX   = 2'(MAX_SNOOZE);

   state_t     state_q, state_d;
   logic [8:0] ring_cnt_q, ring_cnt_d;
   logic [8:0] snz_cnt_q, snz_cnt_d;
   logic [1:0] left_q, left_d;
   logic       stop_kd_q;
   logic       snz_kd_q;
   logic       en_q;
   logic       doing_q;
   logic       snzon_q;

   logic       stop_press;
   logic       snz_press;
   logic       match;
   logic       tick;

   assign tick       = bus.TICK_1HZ;
   assign stop_press = bus.STOP_KEY & ~stop_kd_q;
   assign snz_press  = bus.SNOOZE_KEY & ~snz_kd_q;

   // Alarm fires only on the tick that enters second 0 of the alarm minute
   always_comb begin
      match = tick
            & (bus.CUR_HOUR == bus.AL_HOUR)
            & (bus.CUR_MIN == bus.AL_MIN)
            & (bus.CUR_SEC == 6'd0);
   end

   // Next-state and counter logic; disarm beats stop beats snooze beats tick
   always_comb begin
      state_d    = state_q;
      ring_cnt_d = ring_cnt_q;
      snz_cnt_d  = snz_cnt_q;
      left_d     = left_q;
      if (!bus.AL_ON) begin
         state_d    = S_IDLE;
         ring_cnt_d = 9'd0;
         snz_cnt_d  = 9'd0;
         left_d     = 2'd0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               state_d = S_ARMED;
            end
            S_ARMED: begin
               if (match) begin
                  state_d    = S_RING;
                  ring_cnt_d = 9'd0;
                  left_d     = SNZ_MAX;
               end
            end
            S_RING: begin
               if (stop_press) begin
                  state_d = S_ARMED;
               end else if (snz_press && (left_q != 2'd0)) begin
                  state_d   = S_SNOOZE;
                  snz_cnt_d = 9'd0;
                  left_d    = left_q - 2'd1;
               end else if (tick) begin
                  if (ring_cnt_q == RING_LAST) begin
                     state_d    = S_ARMED;
                     ring_cnt_d = 9'd0;
                  end else begin
                     ring_cnt_d = ring_cnt_q + 9'd1;
                  end
               end
            end
            S_SNOOZE: begin
               if (stop_press) begin
                  state_d = S_ARMED;
               end else if (tick) begin
                  if (snz_cnt_q == SNZ_LAST) begin
                     state_d    = S_RING;
                     ring_cnt_d = 9'd0;
                     snz_cnt_d  = 9'd0;
                  end else begin
                     snz_cnt_d = snz_cnt_q + 9'd1;
                  end
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // State, counters, key history and outputs decoded from next state
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q    <= S_IDLE;
         ring_cnt_q <= 9'd0;
         snz_cnt_q  <= 9'd0;
         left_q     <= 2'd0;
         stop_kd_q  <= 1'b1;
         snz_kd_q   <= 1'b1;
         en_q       <= 1'b0;
         doing_q    <= 1'b0;
         snzon_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         ring_cnt_q <= ring_cnt_d;
         snz_cnt_q  <= snz_cnt_d;
         left_q     <= left_d;
         stop_kd_q  <= bus.STOP_KEY;
         snz_kd_q   <= bus.SNOOZE_KEY;
         en_q       <= (state_d != S_IDLE);
         doing_q    <= (state_d == S_RING);
         snzon_q    <= (state_d == S_SNOOZE);
      end
   end

   assign bus.ALARM_ENABLE = en_q;
   assign bus.ALARM_DOING  = doing_q;
   assign bus.SNOOZE_ON    = snzon_q;
   assign bus.SNOOZE_LEFT  = left_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Bench for alarm_sequencer: vector table, directed ring/snooze
// sequences and random stimulus against a countdown reference model.
module tb_alarm_sequencer;

   localparam int RING_SEC   = 60;
   localparam int SNOOZE_SEC = 300;
   localparam int MAX_SNOOZE = 3;
   localparam int T0730      = 7 * 3600 + 30 * 60;

   localparam int M_IDLE  = 0;
   localparam int M_ARMED = 1;
   localparam int M_RING  = 2;
   localparam int M_SNZ   = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;

   alarm_sequencer_if bus ();

   alarm_sequencer #(
      .RING_SEC  (RING_SEC),
      .SNOOZE_SEC(SNOOZE_SEC),
      .MAX_SNOOZE(MAX_SNOOZE)
   ) dut (
      .CLK  (clk),
      .RESET(rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   int   cur_t = T0730 + 1;
   int   al_h  = 7;
   int   al_m  = 30;
   logic al_v  = 1'b0;
   logic st_v  = 1'b0;
   logic sz_v  = 1'b0;

   // reference model: mode, seconds left in current phase, snoozes left
   int   m_mode  = M_IDLE;
   int   m_secs  = 0;
   int   m_avail = 0;
   logic m_pst   = 1'b1;
   logic m_psz   = 1'b1;

   typedef struct {
      logic       r;
      logic       a;
      logic       st;
      logic       sz;
      logic       tk;
      int         t;
      logic [4:0] exp;
   } vec_t;

   vec_t tbl[25];

   function automatic logic [4:0] dut_out();
      return {bus.ALARM_ENABLE, bus.ALARM_DOING,
              bus.SNOOZE_ON, bus.SNOOZE_LEFT};
   endfunction

   function automatic logic [4:0] m_out();
      return {m_mode != M_IDLE, m_mode == M_RING,
              m_mode == M_SNZ, 2'(m_avail)};
   endfunction

   task automatic check(input string nm, input logic [4:0] got,
                        input logic [4:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s t=%0t got=%b want=%b", nm, $time, got, exp);
      end
   endtask

   task automatic model_update(input logic r, input logic tk);
      logic pst, psz, hit;
      if (r) begin
         m_mode  = M_IDLE;
         m_secs  = 0;
         m_avail = 0;
         m_pst   = 1'b1;
         m_psz   = 1'b1;
         return;
      end
      pst   = st_v && !m_pst;
      psz   = sz_v && !m_psz;
      m_pst = st_v;
      m_psz = sz_v;
      hit   = tk && (cur_t == al_h * 3600 + al_m * 60);
      if (!al_v) begin
         m_mode  = M_IDLE;
         m_avail = 0;
      end else if (m_mode == M_IDLE) begin
         m_mode = M_ARMED;
      end else if (m_mode == M_ARMED) begin
         if (hit) begin
            m_mode  = M_RING;
            m_secs  = RING_SEC;
            m_avail = MAX_SNOOZE;
         end
      end else if (m_mode == M_RING) begin
         if (pst) m_mode = M_ARMED;
         else if (psz && m_avail > 0) begin
            m_mode  = M_SNZ;
            m_secs  = SNOOZE_SEC;
            m_avail = m_avail - 1;
         end else if (tk) begin
            m_secs = m_secs - 1;
            if (m_secs == 0) m_mode = M_ARMED;
         end
      end else begin
         if (pst) m_mode = M_ARMED;
         else if (tk) begin
            m_secs = m_secs - 1;
            if (m_secs == 0) begin
               m_mode = M_RING;
               m_secs = RING_SEC;
            end
         end
      end
   endtask

   task automatic step(input logic r, input logic tk);
      rst            = r;
      bus.AL_ON      = al_v;
      bus.STOP_KEY   = st_v;
      bus.SNOOZE_KEY = sz_v;
      bus.TICK_1HZ   = tk;
      bus.CUR_HOUR   = 5'(cur_t / 3600);
      bus.CUR_MIN    = 6'((cur_t / 60) % 60);
      bus.CUR_SEC    = 6'(cur_t % 60);
      bus.AL_HOUR    = 5'(al_h);
      bus.AL_MIN     = 6'(al_m);
      @(posedge clk);
      model_update(r, tk);
      #1;
      check("model", dut_out(), m_out());
   endtask

   task automatic tick_sec();
      cur_t = (cur_t + 1) % 86400;
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
   endtask

   task automatic ring_now();
      cur_t = T0730 - 1;
      tick_sec();
   endtask

   logic rang;
   logic jump;

   initial begin
      tbl[0]  = '{1, 0, 0, 1, 0, T0730 + 1, 5'b00000};
      tbl[1]  = '{1, 0, 0, 1, 0, T0730 + 1, 5'b00000};
      tbl[2]  = '{0, 0, 0, 1, 0, T0730 + 1, 5'b00000};
      tbl[3]  = '{0, 1, 0, 1, 0, T0730 + 1, 5'b10000};
      tbl[4]  = '{0, 1, 0, 0, 0, T0730 + 1, 5'b10000};
      tbl[5]  = '{0, 1, 0, 1, 0, T0730 + 1, 5'b10000};
      tbl[6]  = '{0, 1, 0, 1, 1, T0730, 5'b11011};
      tbl[7]  = '{0, 1, 0, 0, 0, T0730, 5'b11011};
      tbl[8]  = '{0, 1, 0, 1, 0, T0730, 5'b10110};
      tbl[9]  = '{0, 1, 1, 1, 0, T0730, 5'b10010};
      tbl[10] = '{0, 1, 0, 0, 1, T0730, 5'b11011};
      tbl[11] = '{0, 1, 1, 1, 0, T0730, 5'b10011};
      tbl[12] = '{0, 1, 0, 0, 1, T0730 + 1, 5'b10011};
      tbl[13] = '{0, 1, 0, 0, 1, T0730, 5'b11011};
      tbl[14] = '{0, 0, 0, 0, 0, T0730, 5'b00000};
      tbl[15] = '{0, 1, 0, 0, 1, T0730, 5'b10000};
      tbl[16] = '{0, 1, 0, 0, 1, T0730 + 60, 5'b10000};
      tbl[17] = '{0, 1, 0, 0, 1, T0730 + 3600, 5'b10000};
      tbl[18] = '{0, 1, 0, 0, 1, T0730, 5'b11011};
      tbl[19] = '{0, 1, 0, 1, 0, T0730, 5'b10110};
      tbl[20] = '{0, 0, 0, 1, 0, T0730, 5'b00000};
      tbl[21] = '{0, 1, 0, 0, 0, T0730, 5'b10000};
      tbl[22] = '{0, 1, 0, 0, 1, T0730, 5'b11011};
      tbl[23] = '{1, 1, 0, 0, 0, T0730, 5'b00000};
      tbl[24] = '{0, 1, 0, 0, 0, T0730, 5'b10000};

      for (int i = 0; i < 25; i++) begin
         al_v  = tbl[i].a;
         st_v  = tbl[i].st;
         sz_v  = tbl[i].sz;
         cur_t = tbl[i].t;
         step(tbl[i].r, tbl[i].tk);
         check($sformatf("vec%0d", i), dut_out(), tbl[i].exp);
      end

      // full ring runs out after RING_SEC ticks
      ring_now();
      check("ring_start", dut_out(), 5'b11011);
      for (int i = 0; i < RING_SEC - 1; i++) tick_sec();
      check("ring_hold", dut_out(), 5'b11011);
      tick_sec();
      check("ring_timeout", dut_out(), 5'b10011);

      // re-arm inside the alarm minute: no ring until next 07:30:00
      al_v = 1'b0;
      step(1'b0, 1'b0);
      check("disarm", dut_out(), 5'b00000);
      al_v  = 1'b1;
      step(1'b0, 1'b0);
      cur_t = T0730 + 4;
      rang  = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick_sec();
         rang = rang | bus.ALARM_DOING;
      end
      check("no_refire", {4'd0, rang}, 5'b00000);
      ring_now();
      check("refire", dut_out(), 5'b11011);

      // snooze chain down to zero, then an ignored fourth press
      for (int k = 0; k < MAX_SNOOZE; k++) begin
         sz_v = 1'b1;
         step(1'b0, 1'b0);
         check($sformatf("snooze%0d", k), dut_out(),
               {3'b101, 2'(MAX_SNOOZE - 1 - k)});
         sz_v = 1'b0;
         for (int i = 0; i < SNOOZE_SEC - 1; i++) tick_sec();
         check($sformatf("snz_hold%0d", k), dut_out(),
               {3'b101, 2'(MAX_SNOOZE - 1 - k)});
         tick_sec();
         check($sformatf("resume%0d", k), dut_out(),
               {3'b110, 2'(MAX_SNOOZE - 1 - k)});
      end
      sz_v = 1'b1;
      step(1'b0, 1'b0);
      check("snooze_exhausted", dut_out(), 5'b11000);
      sz_v = 1'b0;
      st_v = 1'b1;
      step(1'b0, 1'b0);
      check("stop_ring", dut_out(), 5'b10000);
      st_v = 1'b0;
      step(1'b0, 1'b0);

      // stop while snoozing
      ring_now();
      sz_v = 1'b1;
      step(1'b0, 1'b0);
      st_v = 1'b1;
      step(1'b0, 1'b0);
      check("stop_snooze", dut_out(), 5'b10010);
      st_v = 1'b0;
      sz_v = 1'b0;
      step(1'b0, 1'b0);

      // disarm while snoozing
      ring_now();
      sz_v = 1'b1;
      step(1'b0, 1'b0);
      sz_v = 1'b0;
      step(1'b0, 1'b0);
      al_v = 1'b0;
      step(1'b0, 1'b0);
      check("alon_snooze", dut_out(), 5'b00000);

      // reset while ringing
      al_v = 1'b1;
      step(1'b0, 1'b0);
      ring_now();
      step(1'b1, 1'b0);
      check("reset_ring", dut_out(), 5'b00000);
      step(1'b0, 1'b0);

      // random keys, resets, disarms and time jumps
      for (int c = 0; c < 14000; c++) begin
         logic r;
         logic tk;
         r  = ($urandom_range(0, 1999) == 0);
         tk = c[0];
         if ($urandom_range(0, 1499) == 0) al_v = ~al_v;
         if ($urandom_range(0, 149) == 0) st_v = ~st_v;
         if ($urandom_range(0, 99) == 0) sz_v = ~sz_v;
         if ($urandom_range(0, 2999) == 0) al_m = 30 + $urandom_range(0, 1);
         if (tk) begin
            jump  = ($urandom_range(0, 39) == 0);
            cur_t = jump ? al_h * 3600 + al_m * 60 : (cur_t + 1) % 86400;
         end
         step(r, tk);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/alarm_sequencer.md
Name: alarm_sequencer

Overview:
- Upstream control stage for the piezo tone generator.
- Compares the running clock time against the user alarm time and sequences ring, snooze, stop and timeout.
- Drives the generator's ALARM_ENABLE (tone counter run) and ALARM_DOING (audible toggle) inputs.
- Sits between the timekeeping/alarm-set registers, the key front end and the piezo unit.

Parameters:
- RING_SEC, 60, seconds a ring lasts before auto-stop (1..511)
- SNOOZE_SEC, 300, seconds of silence per snooze (1..511)
- MAX_SNOOZE, 3, snoozes allowed per alarm event (0..3)

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous reset, active-high
- TICK_1HZ  in  1  one-cycle pulse per second, coincident with the cycle in which CUR_* show the new second
- CUR_HOUR  in  5  current hour, binary 0..23
- CUR_MIN  in  6  current minute, binary 0..59
- CUR_SEC  in  6  current second, binary 0..59
- AL_HOUR  in  5  alarm hour, binary 0..23
- AL_MIN  in  6  alarm minute, binary 0..59
- AL_ON  in  1  alarm arm switch, level
- STOP_KEY  in  1  stop key, level, already debounced
- SNOOZE_KEY  in  1  snooze key, level, already debounced
- ALARM_ENABLE  out  1  piezo tone counter enable
- ALARM_DOING  out  1  piezo audible
- SNOOZE_ON  out  1  high while snoozing
- SNOOZE_LEFT  out  2  snoozes remaining

Behaviour:
- Reset (synchronous, RESET=1 at a CLK edge):
  - state=IDLE; ring_cnt=0; snz_cnt=0; SNOOZE_LEFT=0.
  - All outputs 0.
  - Key-history flops set to 1, so a key held through reset produces no press.
  - Reset overrides everything, including mid-ring.
- Key press: press = key & ~key_d, with key_d registered each cycle. One press per rising edge; holding a key never repeats.
- match = TICK_1HZ & (CUR_HOUR==AL_HOUR) & (CUR_MIN==AL_MIN) & (CUR_SEC==0).
- FSM states: IDLE, ARMED, RING, SNOOZE (2-bit encoding, free choice).
- Global rule: in any state, AL_ON=0 -> IDLE next cycle, with counters cleared.
- IDLE: AL_ON=1 -> ARMED.
- ARMED:
  - match -> RING; ring_cnt=0; SNOOZE_LEFT=MAX_SNOOZE.
  - Keys ignored.
- RING, priority high to low:
  - STOP press -> ARMED.
  - SNOOZE press with SNOOZE_LEFT>0 -> SNOOZE; snz_cnt=0; SNOOZE_LEFT decrements.
  - TICK_1HZ with ring_cnt==RING_SEC-1 -> ARMED (timeout).
  - TICK_1HZ otherwise -> ring_cnt+1.
  - SNOOZE press with SNOOZE_LEFT==0 is ignored; the ring continues.
  - match ignored.
- SNOOZE:
  - STOP press -> ARMED.
  - TICK_1HZ with snz_cnt==SNOOZE_SEC-1 -> RING; ring_cnt=0; SNOOZE_LEFT unchanged.
  - TICK_1HZ otherwise -> snz_cnt+1.
  - SNOOZE press ignored; match ignored.
- Simultaneous events on one edge: AL_ON=0 beats STOP, STOP beats SNOOZE, SNOOZE beats timeout/tick.
- Outputs are registered, decoded from next-state, and valid the cycle after the causing edge (1-cycle latency):
  - ALARM_ENABLE = 1 in ARMED, RING, SNOOZE.
  - ALARM_DOING = 1 only in RING.
  - SNOOZE_ON = 1 only in SNOOZE.
- Re-trigger: a stop or timeout returns to ARMED. Because match needs CUR_SEC==0 of the alarm minute, the alarm does not re-fire until the next day. A stop inside second 0 does not re-fire.
- Counters are 9-bit and never exceed their parameter minus 1. Counter wrap is impossible by construction.
- Changing AL_HOUR or AL_MIN during RING or SNOOZE does not affect the current event.

Test Plan:
- Reset with SNOOZE_KEY held, then release, AL_ON=1 -> ARMED, ENABLE=1, DOING=0, no spurious snooze.
- AL=07:30, clock reaches 07:30:00 on TICK -> DOING=1 next cycle, SNOOZE_LEFT=3. 60 ticks without keys -> DOING=0, state ARMED, ENABLE=1.
- Ring, then SNOOZE press -> DOING=0, SNOOZE_ON=1, LEFT=2. After 300 ticks -> DOING=1, ring_cnt restarts. Repeat until LEFT=0; a fourth SNOOZE press keeps DOING=1.
- STOP and SNOOZE rising on the same edge during RING -> ARMED, LEFT unchanged. STOP during SNOOZE -> ARMED, SNOOZE_ON=0.
- AL_ON dropped mid-RING and mid-SNOOZE -> IDLE next cycle, all outputs 0. Re-arm at 07:30:05 -> no ring until the next 07:30:00.
- RESET asserted mid-RING -> all outputs 0 on the following cycle, state IDLE.
